// File: rtl/median_filter_pkg.sv
// Shared mode encodings and pipeline depth for the streaming 3x3 rank filter.
package median_filter_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_MEDIAN = 2'd1,
        MODE_MIN    = 2'd2,
        MODE_MAX    = 2'd3
    } mode_e;

    localparam int unsigned LATENCY = 4;

endpackage

// File: rtl/sort3.sv
// Combinational min/median/max of three unsigned values; ties yield the shared value.
module sort3 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] mid,
    output logic [DATA_W-1:0] hi
);

    logic [DATA_W-1:0] lo_ab;
    logic [DATA_W-1:0] hi_ab;

    always_comb begin
        lo_ab = (a < b) ? a : b;
        hi_ab = (a < b) ? b : a;
        lo    = (lo_ab < c) ? lo_ab : c;
        hi    = (hi_ab > c) ? hi_ab : c;
        // c clamped into [lo_ab, hi_ab] is the middle value
        if (c > hi_ab) begin
            mid = hi_ab;
        end else if (c < lo_ab) begin
            mid = lo_ab;
        end else begin
            mid = c;
        end
    end

endmodule

// File: rtl/median_filter_stream.sv
// Streaming 3x3 median/min/max filter: two line buffers, sliding window, 4-stage pipeline.
module median_filter_stream
    import median_filter_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_pix,
    output logic              out_valid,
    output logic              out_sof,
    output logic [DATA_W-1:0] out_pix,
    output logic              out_border
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef logic [DATA_W-1:0] pix_t;

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    mode_e         mode_act, cur_mode;

    pix_t lb0 [IMG_W];
    pix_t lb1 [IMG_W];
    pix_t win [3][3];

    logic  s0_v, s0_sof, s0_border;
    pix_t  s0_raw;
    mode_e s0_mode;

    logic  s1_v, s1_sof, s1_border;
    pix_t  s1_raw;
    mode_e s1_mode;
    pix_t  c_lo [3], c_mid [3], c_hi [3];
    pix_t  s1_lo [3], s1_mid [3], s1_hi [3];

    logic  s2_v, s2_sof, s2_border;
    pix_t  s2_raw;
    mode_e s2_mode;
    pix_t  cand_lo, cand_mid, cand_hi, g_min, g_max;
    pix_t  s2_cand_lo, s2_cand_mid, s2_cand_hi, s2_min, s2_max;
    pix_t  s2_unused_lo_mid, s2_unused_mid_lo, s2_unused_mid_hi, s2_unused_hi_mid;

    pix_t  med9, s3_unused_lo, s3_unused_hi, result;

    // A start-of-frame pixel is always (0,0) and carries the newly selected mode
    always_comb begin
        cur_col  = in_sof ? '0 : col;
        cur_row  = in_sof ? '0 : row;
        cur_mode = in_sof ? mode_e'(mode) : mode_act;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            mode_act <= MODE_MEDIAN;
        end else if (in_valid) begin
            mode_act <= cur_mode;
            if (cur_col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    // Line buffers read the old value at cur_col before overwriting it
    always_ff @(posedge clk) begin
        if (rst_n && in_valid) begin
            lb1[cur_col] <= lb0[cur_col];
            lb0[cur_col] <= in_pix;
            win[0][0]    <= win[0][1];
            win[0][1]    <= win[0][2];
            win[0][2]    <= lb1[cur_col];
            win[1][0]    <= win[1][1];
            win[1][1]    <= win[1][2];
            win[1][2]    <= lb0[cur_col];
            win[2][0]    <= win[2][1];
            win[2][1]    <= win[2][2];
            win[2][2]    <= in_pix;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_col
        sort3 #(.DATA_W(DATA_W)) u_col (
            .a   (win[0][i]),
            .b   (win[1][i]),
            .c   (win[2][i]),
            .lo  (c_lo[i]),
            .mid (c_mid[i]),
            .hi  (c_hi[i])
        );
    end

    sort3 #(.DATA_W(DATA_W)) u_los (
        .a   (s1_lo[0]),
        .b   (s1_lo[1]),
        .c   (s1_lo[2]),
        .lo  (g_min),
        .mid (s2_unused_lo_mid),
        .hi  (cand_lo)
    );

    sort3 #(.DATA_W(DATA_W)) u_mids (
        .a   (s1_mid[0]),
        .b   (s1_mid[1]),
        .c   (s1_mid[2]),
        .lo  (s2_unused_mid_lo),
        .mid (cand_mid),
        .hi  (s2_unused_mid_hi)
    );

    sort3 #(.DATA_W(DATA_W)) u_his (
        .a   (s1_hi[0]),
        .b   (s1_hi[1]),
        .c   (s1_hi[2]),
        .lo  (cand_hi),
        .mid (s2_unused_hi_mid),
        .hi  (g_max)
    );

    sort3 #(.DATA_W(DATA_W)) u_final (
        .a   (s2_cand_lo),
        .b   (s2_cand_mid),
        .c   (s2_cand_hi),
        .lo  (s3_unused_lo),
        .mid (med9),
        .hi  (s3_unused_hi)
    );

    always_comb begin
        result = s2_raw;
        if (!s2_border) begin
            case (s2_mode)
                MODE_MEDIAN: result = med9;
                MODE_MIN:    result = s2_min;
                MODE_MAX:    result = s2_max;
                default:     result = s2_raw;
            endcase
        end
    end

    // Data stages run freely; only the valid bits and output register need reset
    always_ff @(posedge clk) begin
        s0_sof      <= in_sof;
        s0_border   <= (32'(cur_row) < 32'd2) || (32'(cur_col) < 32'd2);
        s0_raw      <= in_pix;
        s0_mode     <= cur_mode;

        s1_sof      <= s0_sof;
        s1_border   <= s0_border;
        s1_raw      <= s0_raw;
        s1_mode     <= s0_mode;
        s1_lo       <= c_lo;
        s1_mid      <= c_mid;
        s1_hi       <= c_hi;

        s2_sof      <= s1_sof;
        s2_border   <= s1_border || (s1_mode == MODE_BYPASS);
        s2_raw      <= s1_raw;
        s2_mode     <= s1_mode;
        s2_cand_lo  <= cand_lo;
        s2_cand_mid <= cand_mid;
        s2_cand_hi  <= cand_hi;
        s2_min      <= g_min;
        s2_max      <= g_max;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_v       <= 1'b0;
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_pix    <= '0;
            out_border <= 1'b0;
        end else begin
            s0_v       <= in_valid;
            s1_v       <= s0_v;
            s2_v       <= s1_v;
            out_valid  <= s2_v;
            out_sof    <= s2_v && s2_sof;
            out_pix    <= result;
            out_border <= s2_v && s2_border;
        end
    end

endmodule

// File: tb/tb_median_filter_stream.sv
// Scoreboard bench: an image model predicts each output pixel as stimulus is driven.
module tb_median_filter_stream;
    import median_filter_pkg::*;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_pix = '0;
    logic          out_valid, out_sof, out_border;
    logic [DW-1:0] out_pix;

    always #5 clk = ~clk;

    median_filter_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pix     (in_pix),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_pix    (out_pix),
        .out_border (out_border)
    );

    typedef struct {
        logic [DW-1:0] pix;
        logic          border;
        logic          sof;
        int            r;
        int            c;
        int            want;
    } ent_t;

    ent_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int img[H][W];
    int mrow = 0, mcol = 0, mact = 1;
    logic [LATENCY-1:0] vhist = '0;

    function automatic logic [DW-1:0] ref_pix(int r, int c, int m, int raw);
        int v[9];
        int k = 0;
        int t;
        if (m == 0 || r < 2 || c < 2) return DW'(raw);
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
                v[k] = img[r-2+dr][c-2+dc];
                k++;
            end
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
        if (m == 1) return DW'(v[4]);
        if (m == 2) return DW'(v[0]);
        return DW'(v[8]);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit rn, input bit v, input bit s, input int p, input int m,
                        input int want);
        ent_t e;
        rst_n = rn; in_valid = v; in_sof = s; in_pix = DW'(p); mode = 2'(m);
        if (!rn) begin
            mrow = 0; mcol = 0; mact = 1;
        end else if (v) begin
            if (s) begin
                mrow = 0; mcol = 0; mact = m;
            end
            img[mrow][mcol] = p;
            e.pix    = ref_pix(mrow, mcol, mact, p);
            e.border = (mact == 0 || mrow < 2 || mcol < 2);
            e.sof    = s;
            e.r      = mrow;
            e.c      = mcol;
            e.want   = want;
            sb.push_back(e);
            if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
        @(posedge clk);
        if (!rn) begin
            vhist = '0;
            sb.delete();
        end else begin
            vhist = {vhist[LATENCY-2:0], v};
        end
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(vhist[LATENCY-1]));
        if (!rn) begin
            check_eq("rst_out_pix", 32'(out_pix), 0);
            check_eq("rst_out_sof", 32'(out_sof), 0);
            check_eq("rst_out_border", 32'(out_border), 0);
        end
        if (out_valid === 1'b1 && vhist[LATENCY-1]) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL sb_empty: observed output pix %0d with no expected entry", out_pix);
            end else begin
                e = sb.pop_front();
                check_eq($sformatf("pix(%0d,%0d)", e.r, e.c), 32'(out_pix), 32'(e.pix));
                check_eq($sformatf("border(%0d,%0d)", e.r, e.c), 32'(out_border), 32'(e.border));
                check_eq($sformatf("sof(%0d,%0d)", e.r, e.c), 32'(out_sof), 32'(e.sof));
                if (e.want >= 0 && e.r == 2 && e.c == 2)
                    check_eq("pix22_directed", 32'(out_pix), 32'(e.want));
            end
        end
    endtask

    function automatic int gen_pix(int kind, int idx);
        if (kind == 0) return idx;
        if (kind == 1) return (idx == 2 * W + 2) ? 255 : 50;
        return int'($urandom_range(0, 255));
    endfunction

    task automatic run_frame(input int m, input int kind, input int want, input bit gap,
                             input int sw_at, input int sw_mode);
        int mm;
        for (int idx = 0; idx < W * H; idx++) begin
            mm = (idx >= sw_at) ? sw_mode : m;
            step(1'b1, 1'b1, idx == 0, gen_pix(kind, idx), mm, want);
            if (gap) step(1'b1, 1'b0, 1'b0, 0, mm, -1);
        end
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 0, 0, -1);
        step(1'b0, 1'b0, 1'b0, 0, 0, -1);
        step(1'b1, 1'b0, 1'b0, 0, 0, -1);

        // bypass ramp, then median/min/max of the same ramp
        run_frame(0, 0, 18, 1'b0, W * H, 0);
        run_frame(1, 0, 9, 1'b0, W * H, 1);
        run_frame(2, 0, 0, 1'b0, W * H, 2);
        run_frame(3, 0, 18, 1'b0, W * H, 3);

        // impulse suppression
        run_frame(1, 1, 50, 1'b0, W * H, 1);

        // mode changed mid-frame must not take effect
        run_frame(2, 0, 0, 1'b0, 10, 3);
        run_frame(3, 2, -1, 1'b0, W * H, 3);

        // gapped stream
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 1, -1);
        run_frame(1, 0, 9, 1'b1, W * H, 1);

        // reset at pixel (3,5) of a frame
        for (int idx = 0; idx < 3 * W + 5; idx++)
            step(1'b1, 1'b1, idx == 0, int'($urandom_range(0, 255)), 3, -1);
        step(1'b0, 1'b1, 1'b0, 77, 3, -1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, int'($urandom_range(0, 255)), 3, -1);
        run_frame(1, 2, -1, 1'b0, W * H, 1);
        run_frame(2, 2, -1, 1'b1, W * H, 2);

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 0, 0, -1);
        check_eq("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
